// File: rtl/rv_mem_pkg.sv
// Shared data-memory definitions: RISC-V width codes, LSU state encoding and
// access-size helpers used by the load/store unit and the lane aligner.
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } lsu_state_t;

  // Access size in bytes; illegal codes report 4 (they are rejected anyway).
  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    logic [2:0] size;
    case (funct3)
      F3_B, F3_BU: size = 3'd1;
      F3_H, F3_HU: size = 3'd2;
      F3_W:        size = 3'd4;
      default:     size = 3'd4;
    endcase
    return size;
  endfunction

  // True for the five width codes the memory port understands.
  function automatic logic f3_is_legal(input logic [2:0] funct3);
    logic legal;
    case (funct3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for a 32-bit little-endian word: extracts and
// extends load data, and merges sub-word store data into a read word.
module lsu_lane_align
  import rv_mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halves are naturally aligned, so only lane bit 1 selects the half.
  assign w_byte = i_word[{i_lane, 3'b000} +: 8];
  assign w_half = i_word[{i_lane[1], 4'b0000} +: 16];

  // Load data: pick the addressed lane(s) and sign- or zero-extend.
  always_comb begin
    o_load_data = 32'h0000_0000;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_data = {24'h00_0000, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_data = {16'h0000, w_half};
      F3_W:    o_load_data = i_word;
      default: o_load_data = 32'h0000_0000;
    endcase
  end

  // Store merge: replace only the addressed lane(s) of the read word.
  always_comb begin
    o_store_word = i_word;
    case (i_funct3)
      F3_B:    o_store_word[{i_lane, 3'b000} +: 8]     = i_wdata[7:0];
      F3_H:    o_store_word[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
      F3_W:    o_store_word = i_wdata;
      default: o_store_word = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time toward a word-wide memory port.
// Sub-word stores run as read-modify-write; bad requests never touch memory.
module load_store_unit
  import rv_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_we,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  r_state;
  logic        r_store;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;

  logic [32:0] w_req_end;
  logic        w_is_half;
  logic        w_misaligned;
  logic        w_out_of_range;
  logic        w_bad_store;
  logic        w_req_error;
  logic [31:0] w_load_data;
  logic [31:0] w_store_word;

  // End address is formed in 33 bits so addresses near 2^32 cannot wrap.
  assign w_req_end      = {1'b0, req_addr} + {30'd0, size_of(req_funct3)};
  assign w_is_half      = (req_funct3 == F3_H) || (req_funct3 == F3_HU);
  assign w_misaligned   = (w_is_half && req_addr[0]) ||
                          ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
  assign w_out_of_range = w_req_end > 33'(MEM_BYTES);
  assign w_bad_store    = req_store && ((req_funct3 == F3_BU) || (req_funct3 == F3_HU));
  assign w_req_error    = !f3_is_legal(req_funct3) || w_misaligned ||
                          w_out_of_range || w_bad_store;

  // Memory read data is combinational, so it is steered in the READ cycle.
  lsu_lane_align u_lane_align (
    .i_word       (mem_rdata),
    .i_lane       (r_lane),
    .i_funct3     (r_funct3),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word)
  );

  // Control FSM; every port output is registered and set on state entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_store     <= 1'b0;
      r_funct3    <= 3'b000;
      r_lane      <= 2'b00;
      r_wdata     <= 32'h0000_0000;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'h0000_0000;
      resp_error  <= 1'b0;
      mem_we      <= 1'b0;
      mem_address <= 32'h0000_0000;
      mem_wdata   <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_store     <= req_store;
            r_funct3    <= req_funct3;
            r_lane      <= req_addr[1:0];
            r_wdata     <= req_wdata;
            mem_address <= {req_addr[31:2], 2'b00};
            req_ready   <= 1'b0;
            if (w_req_error) begin
              r_state    <= ST_RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= 32'h0000_0000;
            end else if (req_store && (req_funct3 == F3_W)) begin
              r_state   <= ST_WRITE;
              mem_we    <= 1'b1;
              mem_wdata <= req_wdata;
            end else begin
              r_state <= ST_READ;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (r_store) begin
            r_state   <= ST_WRITE;
            mem_we    <= 1'b1;
            mem_wdata <= w_store_word;
          end else begin
            r_state    <= ST_RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= w_load_data;
          end
        end
        ST_WRITE: begin
          r_state    <= ST_RESP;
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_rdata <= 32'h0000_0000;
        end
        ST_RESP: begin
          r_state    <= ST_IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          r_state    <= ST_IDLE;
          mem_we     <= 1'b0;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-array memory model and
// a scoreboard queue of expected responses.
module tb_load_store_unit;
  import rv_mem_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_we;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [7:0] mem [0:63];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  load_store_unit #(.MEM_BYTES(64)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_store   (req_store),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_error  (resp_error),
    .mem_we      (mem_we),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clock = ~clock;

  // Little-endian memory model: combinational read, clocked word write.
  assign mem_rdata = {mem[{mem_address[5:2], 2'd3}], mem[{mem_address[5:2], 2'd2}],
                      mem[{mem_address[5:2], 2'd1}], mem[{mem_address[5:2], 2'd0}]};

  always @(posedge clock) begin
    if (mem_we) begin
      mem[{mem_address[5:2], 2'd0}] <= mem_wdata[7:0];
      mem[{mem_address[5:2], 2'd1}] <= mem_wdata[15:8];
      mem[{mem_address[5:2], 2'd2}] <= mem_wdata[23:16];
      mem[{mem_address[5:2], 2'd3}] <= mem_wdata[31:24];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One request: push expectation, then watch write pulse, ready and response.
  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                         input int exp_lat, input int exp_we_k, input logic [31:0] exp_wa,
                         input logic [31:0] exp_wd, input string name);
    exp_t e;
    exp_t got;
    int   we_seen;
    bit   done;
    we_seen = 0;
    done    = 1'b0;
    @(negedge clock);
    for (int t = 0; t < 10 && req_ready !== 1'b1; t++) @(negedge clock);
    if (req_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s idle_wait: req_ready got %b want 1", name, req_ready);
      return;
    end
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat;
    sb_q.push_back(e);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k == 1) req_valid = 1'b0;
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s ready_busy: cycle %0d got %b want 0", name, k, req_ready);
      end
      if (mem_we === 1'b1) begin
        we_seen++;
        checks++;
        if (k != exp_we_k || mem_address !== exp_wa || mem_wdata !== exp_wd) begin
          errors++;
          $display("FAIL %s write: cycle %0d addr %h data %h want cycle %0d addr %h data %h",
                   name, k, mem_address, mem_wdata, exp_we_k, exp_wa, exp_wd);
        end
      end
      if (resp_valid === 1'b1) begin
        got = sb_q.pop_front();
        checks += 3;
        if (resp_rdata !== got.rdata) begin
          errors++;
          $display("FAIL %s rdata: got %h want %h", name, resp_rdata, got.rdata);
        end
        if (resp_error !== got.err) begin
          errors++;
          $display("FAIL %s error: got %b want %b", name, resp_error, got.err);
        end
        if (k != got.lat) begin
          errors++;
          $display("FAIL %s latency: got %0d want %0d", name, k, got.lat);
        end
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s timeout: no resp_valid within 8 cycles", name);
      void'(sb_q.pop_front());
    end
    checks++;
    if (we_seen != ((exp_we_k != 0) ? 1 : 0)) begin
      errors++;
      $display("FAIL %s write_count: got %0d want %0d", name, we_seen, (exp_we_k != 0) ? 1 : 0);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 ||
        resp_error !== 1'b0 || mem_we !== 1'b0 || mem_address !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL %s: got rdy %b rv %b rd %h re %b we %b ma %h wd %h want 1 0 0 0 0 0 0",
               name, req_ready, resp_valid, resp_rdata, resp_error, mem_we, mem_address, mem_wdata);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_idle_outputs("reset_state");
    reset = 1'b0;
  endtask

  task automatic test_preload_and_loads();
    run_req(1'b1, F3_W, 32'd0, 32'h01FF_7F80, 32'h0, 1'b0, 2, 1, 32'd0, 32'h01FF_7F80, "sw0");
    run_req(1'b1, F3_W, 32'd4, 32'hAABB_CCDD, 32'h0, 1'b0, 2, 1, 32'd4, 32'hAABB_CCDD, "sw4");
    run_req(1'b0, F3_B,  32'd0, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 0, 32'h0, 32'h0, "lb0");
    run_req(1'b0, F3_BU, 32'd0, 32'h0, 32'h0000_0080, 1'b0, 2, 0, 32'h0, 32'h0, "lbu0");
    run_req(1'b0, F3_H,  32'd2, 32'h0, 32'h0000_01FF, 1'b0, 2, 0, 32'h0, 32'h0, "lh2");
    run_req(1'b0, F3_W,  32'd0, 32'h0, 32'h01FF_7F80, 1'b0, 2, 0, 32'h0, 32'h0, "lw0");
    run_req(1'b0, F3_B,  32'd1, 32'h0, 32'h0000_007F, 1'b0, 2, 0, 32'h0, 32'h0, "lb1");
    run_req(1'b0, F3_B,  32'd2, 32'h0, 32'hFFFF_FFFF, 1'b0, 2, 0, 32'h0, 32'h0, "lb2");
    run_req(1'b0, F3_H,  32'd0, 32'h0, 32'h0000_7F80, 1'b0, 2, 0, 32'h0, 32'h0, "lh0");
    run_req(1'b0, F3_HU, 32'd2, 32'h0, 32'h0000_01FF, 1'b0, 2, 0, 32'h0, 32'h0, "lhu2");
    run_req(1'b0, F3_BU, 32'd3, 32'h0, 32'h0000_0001, 1'b0, 2, 0, 32'h0, 32'h0, "lbu3");
    run_req(1'b0, F3_H,  32'd6, 32'h0, 32'hFFFF_AABB, 1'b0, 2, 0, 32'h0, 32'h0, "lh6");
  endtask

  task automatic test_subword_stores();
    run_req(1'b1, F3_B, 32'd5, 32'h0000_0011, 32'h0, 1'b0, 3, 2, 32'd4, 32'hAABB_11DD, "sb5");
    run_req(1'b0, F3_W, 32'd4, 32'h0, 32'hAABB_11DD, 1'b0, 2, 0, 32'h0, 32'h0, "lw4_after_sb");
    run_req(1'b1, F3_H, 32'd6, 32'hFFFF_1234, 32'h0, 1'b0, 3, 2, 32'd4, 32'h1234_11DD, "sh6");
    run_req(1'b0, F3_W, 32'd4, 32'h0, 32'h1234_11DD, 1'b0, 2, 0, 32'h0, 32'h0, "lw4_after_sh");
    run_req(1'b1, F3_W, 32'd8, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1, 32'd8, 32'hDEAD_BEEF, "sw8");
    run_req(1'b0, F3_W, 32'd8, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0, 32'h0, 32'h0, "lw8");
    run_req(1'b1, F3_W, 32'd60, 32'h0C0B_0A09, 32'h0, 1'b0, 2, 1, 32'd60, 32'h0C0B_0A09, "sw60");
    run_req(1'b0, F3_BU, 32'd63, 32'h0, 32'h0000_000C, 1'b0, 2, 0, 32'h0, 32'h0, "lbu63");
    run_req(1'b0, F3_H,  32'd62, 32'h0, 32'h0000_0C0B, 1'b0, 2, 0, 32'h0, 32'h0, "lh62");
    run_req(1'b1, F3_B,  32'd63, 32'h0000_00A5, 32'h0, 1'b0, 3, 2, 32'd60, 32'hA50B_0A09, "sb63");
  endtask

  task automatic test_errors();
    run_req(1'b0, F3_H,   32'd1,  32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0, "err_lh1");
    run_req(1'b0, F3_W,   32'd2,  32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0, "err_lw2");
    run_req(1'b1, F3_W,   32'd62, 32'h1, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0, "err_sw62");
    run_req(1'b0, 3'b011, 32'd0,  32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0, "err_f3_011");
    run_req(1'b0, F3_B,   32'd64, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0, "err_lb64");
    run_req(1'b1, F3_BU,  32'd0,  32'h5, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0, "err_store_bu");
    run_req(1'b0, F3_W,   32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0, "err_wrap");
    run_req(1'b1, F3_H,   32'd3,  32'h7, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0, "err_sh3");
    run_req(1'b0, F3_W,   32'd0,  32'h0, 32'h01FF_7F80, 1'b0, 2, 0, 32'h0, 32'h0, "lw0_after_err");
  endtask

  // Two SWs with req_valid held high: second accepted only after RESP.
  task automatic test_back_to_back();
    exp_t e;
    exp_t got;
    int   we_k[$];
    int   rs_k[$];
    int   exp_lat[$];
    int   n;
    @(negedge clock);
    for (int t = 0; t < 10 && req_ready !== 1'b1; t++) @(negedge clock);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = F3_W; req_addr = 32'd12; req_wdata = 32'h1111_2222;
    e.rdata = 32'h0; e.err = 1'b0; e.lat = 2; sb_q.push_back(e);
    e.lat = 5; sb_q.push_back(e);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k == 1) begin
        req_addr = 32'd16; req_wdata = 32'h3333_4444;
      end
      if (k == 4) req_valid = 1'b0;
      if (k <= 3) begin
        checks++;
        if (req_ready !== ((k == 3) ? 1'b1 : 1'b0)) begin
          errors++;
          $display("FAIL b2b_ready: cycle %0d got %b want %b", k, req_ready, (k == 3) ? 1'b1 : 1'b0);
        end
      end
      if (mem_we === 1'b1) begin
        we_k.push_back(k);
        checks++;
        if (mem_address !== ((k == 1) ? 32'd12 : 32'd16) ||
            mem_wdata !== ((k == 1) ? 32'h1111_2222 : 32'h3333_4444)) begin
          errors++;
          $display("FAIL b2b_write: cycle %0d addr %h data %h", k, mem_address, mem_wdata);
        end
      end
      if (resp_valid === 1'b1) begin
        rs_k.push_back(k);
        if (sb_q.size() > 0) begin
          got = sb_q.pop_front();
          exp_lat.push_back(got.lat);
          checks++;
          if (resp_rdata !== got.rdata || resp_error !== got.err || k != got.lat) begin
            errors++;
            $display("FAIL b2b_resp: cycle %0d rdata %h err %b want cycle %0d rdata %h err %b",
                     k, resp_rdata, resp_error, got.lat, got.rdata, got.err);
          end
        end
      end
    end
    n = we_k.size();
    checks++;
    if (n != 2 || we_k[0] != 1 || we_k[1] != 4) begin
      errors++;
      $display("FAIL b2b_write_cycles: got %0d pulses want 2 at cycles 1 and 4", n);
    end
    checks++;
    if (rs_k.size() != 2) begin
      errors++;
      $display("FAIL b2b_resp_count: got %0d want 2", rs_k.size());
    end
    while (sb_q.size() > 0) void'(sb_q.pop_front());
    run_req(1'b0, F3_W, 32'd12, 32'h0, 32'h1111_2222, 1'b0, 2, 0, 32'h0, 32'h0, "b2b_lw12");
    run_req(1'b0, F3_W, 32'd16, 32'h0, 32'h3333_4444, 1'b0, 2, 0, 32'h0, 32'h0, "b2b_lw16");
  endtask

  // Reset sampled in the READ cycle of an SB aborts it without a write.
  task automatic test_reset_mid_op();
    @(negedge clock);
    for (int t = 0; t < 10 && req_ready !== 1'b1; t++) @(negedge clock);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = F3_B; req_addr = 32'd5; req_wdata = 32'h0000_0055;
    @(negedge clock);
    req_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_read_cycle: we %b ready %b want 0 0", mem_we, req_ready);
    end
    reset = 1'b1;
    @(negedge clock);
    check_idle_outputs("rst_mid_op_outputs");
    reset = 1'b0;
    run_req(1'b0, F3_W, 32'd4, 32'h0, 32'h1234_11DD, 1'b0, 2, 0, 32'h0, 32'h0, "rst_mem_unchanged");
  endtask

  initial begin
    test_reset();
    test_preload_and_loads();
    test_subword_stores();
    test_errors();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts one load/store request at a time from the core and drives the byte-addressed 32-bit memory port.
- Sub-word stores (SB/SH) become read-modify-write sequences, because the memory always writes 4 bytes.
- Load results are lane-extracted and sign- or zero-extended.
- Misaligned and out-of-range accesses are flagged as errors; memory is never touched for them.

Parameters:
- MEM_BYTES, 64, size of the attached memory in bytes. A legal access satisfies addr + size <= MEM_BYTES.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  LSU idle, can accept a request
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte/half used for SB/SH
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  misaligned, out-of-range or illegal funct3
- mem_we  out  1  memory write enable
- mem_address  out  32  word-aligned address to memory
- mem_wdata  out  32  data to memory data_in
- mem_rdata  in  32  memory data_out, combinational read

Behaviour:
- Reset (clock, reset, active-high, synchronous):
  - state = IDLE; req_ready = 1; resp_valid = 0; resp_rdata = 0; resp_error = 0; mem_we = 0; mem_address = 0; mem_wdata = 0.
- Reset during any state aborts the operation. No write is issued in the cycle reset is sampled.
- mem_address is always {addr[31:2], 2'b00} of the latched request. Lane index = addr[1:0].
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready = 1.
  - Accepts on req_valid at the clock edge and latches store, funct3, addr and wdata.
  - Error check uses size = 1/2/4. Error if any of:
    - H with addr[0] != 0;
    - W with addr[1:0] != 0;
    - addr + size > MEM_BYTES (compare in 33 bits, no wrap);
    - funct3 not in the legal set;
    - a store with funct3 BU or HU.
  - On error -> RESP with resp_error = 1.
  - Load or sub-word store -> READ. SW -> WRITE.
- READ:
  - mem_we = 0; samples mem_rdata into a word register.
  - Load -> RESP, with resp_rdata computed from the word:
    - B/BU: byte lane, sign- or zero-extended.
    - H/HU: half at lanes {addr[1],0}, extended.
    - W: whole word.
  - Store -> WRITE, with merge data = sampled word with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
- WRITE:
  - mem_we = 1 for exactly this one cycle.
  - mem_wdata = merged word (SB/SH) or wdata (SW).
  - -> RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle; resp_rdata and resp_error held valid.
  - req_ready = 0.
  - -> IDLE.
- Outside RESP: resp_valid = 0. resp_rdata and resp_error hold their values until the next response.
- Latency, with the accept edge as cycle 0 and resp_valid high in cycle N:
  - error: N = 1
  - load: N = 2
  - SW: N = 2 (write at cycle 1)
  - SB/SH: N = 3 (read at cycle 1, write at cycle 2)
- req_valid outside IDLE is ignored; no queuing. A new request may be accepted in the cycle after RESP.
- mem_we must never assert for an errored request.

Decomposition:
- Shared package rv_mem_pkg:
  - funct3 width constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - LSU state encoding;
  - function size_of(funct3).
- One natural sub-module, lsu_lane_align (combinational):
  - given word, addr[1:0], funct3 and store data, produces the extended load value and the merged store word;
  - reused later by the cache.

Test Plan:
- Memory bytes 0..3 = 0x80,0x7F,0xFF,0x01; LB addr 0 -> resp_rdata 0xFFFFFF80 at N=2; LBU addr 0 -> 0x00000080; LH addr 2 -> 0x000001FF; LW addr 0 -> 0x01FF7F80.
- Word 4 = 0xAABBCCDD; SB addr 5 data 0x11 -> one mem_we pulse at cycle 2 with mem_address 4, mem_wdata 0xAABB11DD; resp at N=3; subsequent LW 4 returns 0xAABB11DD.
- SH addr 6 data 0x1234 on word 0xAABB11DD -> write 0x123411DD; SW addr 8 data 0xDEADBEEF -> mem_we at cycle 1, resp at N=2.
- LH addr 1, LW addr 2, SW addr 62 (MEM_BYTES=64), funct3 011 -> resp_error = 1 at N=1, mem_we never asserted, resp_rdata = 0.
- Back-to-back: req_valid held high across two SW requests -> second accepted only after RESP (req_ready low during WRITE and RESP); req_valid asserted mid-operation is ignored.
- Assert reset during the READ cycle of an SB -> no mem_we, req_ready = 1 and all outputs 0 the following cycle, memory unchanged.
